// File: rtl/lzw_code_packer.sv
// lzw_code_packer
// Reads fixed-width LZW codes from the encoder's output code RAM through a
// synchronous read port. Packs them MSB-first into a continuous bitstream and
// emits that stream as DATA_WIDTH-bit words over a valid/ready interface. Any
// partial final word is left-justified and zero-padded.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cs              level start; sampled in IDLE and DONE
//   code_count      number of codes to pack (0..2^ADDR_WIDTH), latched on start
//   code_addr       code RAM read address
//   code_rd         code RAM read enable (one-cycle pulse per code)
//   code_rdata      code RAM data, valid one cycle after code_rd
//   out_data        packed output word
//   out_valid       out_data valid
//   out_ready       sink accepts when out_valid && out_ready
//   done            packing complete (DONE state)
//   busy            high in every state except IDLE and DONE
module lzw_code_packer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CODE_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic [ADDR_WIDTH:0]   code_count,
  output logic [ADDR_WIDTH-1:0] code_addr,
  output logic                  code_rd,
  input  logic [CODE_WIDTH-1:0] code_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  busy
);

  localparam int ACC_W = CODE_WIDTH + DATA_WIDTH;
  localparam int NB_W  = $clog2(ACC_W) + 1;

  typedef enum logic [2:0] {IDLE, READ, WAIT, PACK, EMIT, FLUSH, DONE} state_t;

  state_t                state, state_nxt;
  // Valid bits sit right-justified in acc; bits above nbits are stale.
  logic [ACC_W-1:0]      acc;
  logic [NB_W-1:0]       nbits;
  logic [NB_W-1:0]       nbits_left;
  logic [CODE_WIDTH-1:0] code_q;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  have_word;

  // Oldest DATA_WIDTH valid bits, i.e. the top of the nbits-wide window.
  function automatic logic [DATA_WIDTH-1:0] top_word(input logic [ACC_W-1:0] a,
                                                     input logic [NB_W-1:0]  n);
    logic [ACC_W-1:0] s;
    s = a >> (n - NB_W'(DATA_WIDTH));
    return s[DATA_WIDTH-1:0];
  endfunction

  // Remaining n (< DATA_WIDTH) bits moved to the MSBs, zeros shifted in below.
  function automatic logic [DATA_WIDTH-1:0] flush_word(input logic [ACC_W-1:0] a,
                                                       input logic [NB_W-1:0]  n);
    logic [ACC_W-1:0] s;
    s = a << (NB_W'(DATA_WIDTH) - n);
    return s[DATA_WIDTH-1:0];
  endfunction

  assign have_word  = (nbits >= NB_W'(DATA_WIDTH));
  // Bit count after this cycle's EMIT handshake; lets EMIT leave on the same
  // cycle its last full word is accepted, so no idle EMIT cycle is spent.
  assign nbits_left = (state == EMIT && have_word && out_ready)
                      ? nbits - NB_W'(DATA_WIDTH) : nbits;

  assign code_addr = addr_q;
  assign code_rd   = (state == READ);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE) && (state != DONE);

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = '0;
    case (state)
      IDLE:  if (cs) state_nxt = (code_count == '0) ? DONE : READ;
      READ:  state_nxt = WAIT;
      WAIT:  state_nxt = PACK;
      PACK:  state_nxt = EMIT;
      EMIT: begin
        if (have_word) begin
          out_valid = 1'b1;
          out_data  = top_word(acc, nbits);
        end
        if (nbits_left < NB_W'(DATA_WIDTH)) begin
          if (remaining != '0)        state_nxt = READ;
          else if (nbits_left != '0)  state_nxt = FLUSH;
          else                        state_nxt = DONE;
        end
      end
      FLUSH: begin
        out_valid = 1'b1;
        out_data  = flush_word(acc, nbits);
        if (out_ready) state_nxt = DONE;
      end
      DONE:  if (!cs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      nbits     <= '0;
      code_q    <= '0;
      remaining <= '0;
      addr_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (cs) begin
          remaining <= code_count;
          addr_q    <= '0;
          acc       <= '0;
          nbits     <= '0;
        end
        WAIT:  code_q <= code_rdata;
        PACK: begin
          acc       <= (acc << CODE_WIDTH) | ACC_W'(code_q);
          nbits     <= nbits + NB_W'(CODE_WIDTH);
          addr_q    <= addr_q + ADDR_WIDTH'(1);
          remaining <= remaining - (ADDR_WIDTH+1)'(1);
        end
        EMIT:  nbits <= nbits_left;
        FLUSH: if (out_ready) nbits <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lzw_code_packer.sv
module tb_lzw_code_packer;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst, cs;
  logic [AW:0]   code_count;
  logic [AW-1:0] code_addr;
  logic          code_rd;
  logic [CW-1:0] code_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, done, busy;

  always #5 clk = ~clk;

  lzw_code_packer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CODE_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cs(cs), .code_count(code_count),
    .code_addr(code_addr), .code_rd(code_rd), .code_rdata(code_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .busy(busy)
  );

  // Code RAM with one-cycle synchronous read
  logic [CW-1:0] mem [16];
  always @(posedge clk) if (code_rd) code_rdata <= mem[code_addr];

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] got[$];
  logic [DW-1:0] exp_q[$];
  int            rd_addr[$];
  int            stab_err = 0;
  int            vld_err  = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev;

  // Monitor on the falling edge: record handshakes and reads, watch stalls
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && (!out_valid || out_data !== data_prev)) stab_err++;
      if (out_valid && out_ready) got.push_back(out_data);
      if (code_rd) rd_addr.push_back(int'(code_addr));
      if (out_valid && !busy) vld_err++;
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
    end
  end

  // Reference: flatten codes to a bit queue MSB-first, cut into words, pad.
  task automatic build_exp(input int n);
    bit            b[$];
    logic [DW-1:0] w;
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int k = CW - 1; k >= 0; k--) b.push_back(mem[i][k]);
    while (b.size() > 0) begin
      w = '0;
      for (int k = 0; k < DW; k++) w = {w[DW-2:0], (b.size() > 0) ? b.pop_front() : 1'b0};
      exp_q.push_back(w);
    end
  endtask

  // mode 0: ready always 1; 1: ready low 5 cycles per new word; 2: random ready
  task automatic run_job(input string name, input int n, input int mode);
    int cyc, stall, nrd, ngot;
    bit fin, last_v, hs_prev;
    build_exp(n);
    @(posedge clk); #1;
    got.delete(); rd_addr.delete(); stab_err = 0; vld_err = 0;
    code_count = (AW+1)'(n);
    cs = 1'b1;
    out_ready = (mode != 1);
    cyc = 0; stall = 0; fin = 0; last_v = 0;
    while (!fin && cyc < 3000) begin
      @(posedge clk); cyc++; #1;
      if (done) fin = 1;
      else begin
        hs_prev = last_v && out_ready;
        if (mode == 1) begin
          if (out_valid && (!last_v || hs_prev)) stall = 5;
          out_ready = (stall == 0);
          if (stall > 0) stall--;
        end else if (mode == 2) begin
          out_ready = 1'($urandom_range(0, 1));
        end
        last_v = out_valid;
      end
    end
    n_cmp++;
    if (!fin) begin n_err++; $display("FAIL %s timeout: done=%0b after %0d cycles, required 1", name, done, cyc); end
    if (mode == 0) begin
      n_cmp++;
      if (cyc != 1 + 3*n + exp_q.size()) begin
        n_err++; $display("FAIL %s cycles: got %0d required %0d", name, cyc, 1 + 3*n + exp_q.size());
      end
    end
    n_cmp++;
    if (got.size() != exp_q.size()) begin
      n_err++; $display("FAIL %s word_count: got %0d required %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_err++; $display("FAIL %s word[%0d]: got %h required %h", name, i, got[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (rd_addr.size() != n) begin
      n_err++; $display("FAIL %s read_count: got %0d required %0d", name, rd_addr.size(), n);
    end
    for (int i = 0; i < rd_addr.size() && i < n; i++) begin
      n_cmp++;
      if (rd_addr[i] != i) begin
        n_err++; $display("FAIL %s read_addr[%0d]: got %0d required %0d", name, i, rd_addr[i], i);
      end
    end
    n_cmp++;
    if (stab_err != 0 || vld_err != 0) begin
      n_err++; $display("FAIL %s stall_stability: unstable=%0d valid_not_busy=%0d required 0/0", name, stab_err, vld_err);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_in_done: got %b required 0", name, busy); end
    // cs stays high in DONE: must not restart
    nrd = rd_addr.size(); ngot = got.size();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1 || rd_addr.size() != nrd || got.size() != ngot) begin
      n_err++; $display("FAIL %s hold_done: done=%b reads=%0d words=%0d required 1/%0d/%0d", name, done, rd_addr.size(), got.size(), nrd, ngot);
    end
    cs = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s release: done=%b busy=%b required 0/0", name, done, busy);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (code_addr !== '0 || code_rd !== 1'b0 || out_data !== '0 || out_valid !== 1'b0 ||
        done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_state: addr=%h rd=%b data=%h valid=%b done=%b busy=%b required all 0",
                        code_addr, code_rd, out_data, out_valid, done, busy);
    end
  endtask

  task automatic test_two_codes();
    mem[0] = 12'hABC; mem[1] = 12'h123;
    run_job("two_codes", 2, 0);
    n_cmp++;
    if (got.size() != 3 || got[0] !== 8'hAB || got[1] !== 8'hC1 || got[2] !== 8'h23) begin
      n_err++; $display("FAIL two_codes_literal: got %0d words required AB C1 23", got.size());
    end
  endtask

  task automatic test_flush();
    mem[0] = 12'h041; mem[1] = 12'h042; mem[2] = 12'h100;
    run_job("flush", 3, 0);
    n_cmp++;
    if (got.size() != 5 || got[0] !== 8'h04 || got[1] !== 8'h10 || got[2] !== 8'h42 ||
        got[3] !== 8'h10 || got[4] !== 8'h00) begin
      n_err++; $display("FAIL flush_literal: got %0d words required 04 10 42 10 00", got.size());
    end
  endtask

  task automatic test_backpressure();
    mem[0] = 12'hABC; mem[1] = 12'h123;
    run_job("backpressure", 2, 1);
  endtask

  task automatic test_zero_count();
    run_job("zero_a", 0, 0);
    run_job("zero_b", 0, 0);
  endtask

  task automatic test_full_count();
    for (int i = 0; i < 16; i++) mem[i] = CW'(i);
    run_job("full16", 16, 0);
    n_cmp++;
    if (got.size() != 24) begin
      n_err++; $display("FAIL full16_words: got %0d required 24", got.size());
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 16; i++) mem[i] = CW'($urandom);
      run_job($sformatf("random%0d", j), $urandom_range(1, 16), (j == 4) ? 1 : 2);
    end
  endtask

  task automatic test_reset_mid_emit();
    int w;
    for (int i = 0; i < 16; i++) mem[i] = CW'($urandom);
    @(posedge clk); #1;
    code_count = 5'd3; cs = 1'b1; out_ready = 1'b0;
    w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); w++; #1; end
    n_cmp++;
    if (!out_valid) begin n_err++; $display("FAIL rst_mid_wait: out_valid=%b required 1", out_valid); end
    rst = 1'b1; cs = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || code_addr !== '0 || code_rd !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_emit: valid=%b busy=%b addr=%h rd=%b done=%b required 0/0/0/0/0",
                        out_valid, busy, code_addr, code_rd, done);
    end
    rst = 1'b0; out_ready = 1'b1;
    run_job("after_rst", 3, 0);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; out_ready = 1'b1; code_count = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_two_codes();
    test_flush();
    test_backpressure();
    test_zero_count();
    test_full_count();
    test_random();
    test_reset_mid_emit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lzw_code_packer.md
Name: lzw_code_packer

Overview:
Downstream stage of the LZW encoder. After the encoder finishes, this block reads its fixed-width output codes from the output code RAM through a synchronous read port. It packs the codes MSB-first into a continuous bitstream and emits that stream as DATA_WIDTH-bit words over a valid/ready interface for the serial/DMA sink. When the last code has been packed, any partial final word is zero-padded and emitted.

Parameters:
ADDR_WIDTH, 4, address width of the code RAM read port
DATA_WIDTH, 8, width of each packed output word
CODE_WIDTH, 12, width of each code word stored in the code RAM

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cs  in  1  start/enable; level-sensitive, sampled in IDLE and DONE
code_count  in  ADDR_WIDTH+1  number of valid codes (0..2^ADDR_WIDTH); sampled on start
code_addr  out  ADDR_WIDTH  code RAM read address
code_rd  out  1  code RAM read enable
code_rdata  in  CODE_WIDTH  code RAM read data, valid exactly 1 cycle after code_rd
out_data  out  DATA_WIDTH  packed output word
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts word when out_valid && out_ready
done  out  1  packing complete; high in DONE
busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; code_addr=0, code_rd=0, out_data=0, out_valid=0, done=0, busy=0; accumulator and bit count cleared. Reset mid-operation aborts immediately. No word is emitted and no read is issued on the cycle after reset.
- Datapath: accumulator `acc` of width CODE_WIDTH+DATA_WIDTH, plus bit count `nbits` of width clog2(CODE_WIDTH+DATA_WIDTH)+1. New codes are appended below the existing bits. Output words are taken from the top nbits MSB-first.
- FSM states: IDLE, READ, WAIT, PACK, EMIT, FLUSH, DONE.
- IDLE: if cs=1, latch code_count into `remaining`, set code_addr=0, busy=1.
  - If the latched count is 0, go to DONE.
  - Otherwise go to READ.
- READ: code_rd=1 for exactly one cycle at code_addr; go to WAIT.
- WAIT: code_rd=0; go to PACK. code_rdata is captured on the WAIT->PACK edge.
- PACK: append the captured code (nbits += CODE_WIDTH), code_addr++, remaining--; go to EMIT.
- EMIT: while nbits >= DATA_WIDTH, present the top DATA_WIDTH bits with out_valid=1.
  - On a handshake, remove those bits (nbits -= DATA_WIDTH).
  - At most one word per cycle. out_data and out_valid stay stable until accepted.
  - When nbits < DATA_WIDTH: go to READ if remaining != 0; else go to FLUSH if nbits > 0; else go to DONE.
- FLUSH: present the remaining nbits left-justified, low bits zero-padded, with out_valid=1. On acceptance, nbits=0 and go to DONE.
- DONE: done=1, busy=0, out_valid=0. Hold until cs=0, then return to IDLE; done falls on that edge. cs held high in DONE does not restart.
- Invariant: nbits never exceeds CODE_WIDTH+DATA_WIDTH-1. The next code is read only when nbits < DATA_WIDTH.
- Address wrap: code_count = 2^ADDR_WIDTH reads addresses 0..2^ADDR_WIDTH-1. code_addr wraps to 0 after the last PACK, which is harmless.
- Throughput: with out_ready held at 1, each code costs 3 cycles (READ/WAIT/PACK) plus 1 cycle per emitted word.
- Total words emitted = ceil(code_count*CODE_WIDTH / DATA_WIDTH).
- Changes to cs or code_count while busy are ignored.

Test Plan:
- Two codes 0xABC, 0x123, out_ready=1 -> words 0xAB, 0xC1, 0x23 in order; no FLUSH word; done=1; code_rd pulsed exactly twice, at addresses 0 and 1.
- Three codes 0x041, 0x042, 0x100 -> words 0x04, 0x10, 0x42, 0x10, then flush word 0x00 (4 data bits plus 4 pad bits); exactly 5 handshakes.
- Backpressure: same stimulus as the first scenario, with out_ready low for 5 cycles whenever out_valid rises -> out_data stable while stalled; identical word sequence; no dropped or duplicated words.
- code_count=0, cs=1 -> DONE within 1 cycle; no code_rd; no out_valid. Drop cs -> IDLE; raise cs again -> repeats.
- code_count=16, codes = their own address (0x000..0x00F) -> 24 words; last read at address 15; done asserted; cs held high does not restart.
- rst pulsed for 1 cycle mid-EMIT with out_valid=1 -> next cycle out_valid=0, busy=0, code_addr=0. A fresh start then produces the correct full sequence.
